fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO; next generation of the team's 8x8 FIFO.
- Generalised in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a defined simultaneous insert/remove rule.
- Sits between a producer and consumer sharing one clock, e.g. a packet staging buffer in front of a serialiser.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk_in  input  1  the single clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of FIFO contents and flags
insert  input  1  write request
remove  input  1  read request
data_in  input  WIDTH  write data
data_out  output  WIDTH  read data
data_valid  output  1  data_out holds a valid popped word (see Behaviour)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: insert attempted while full and no pop
underflow  output  1  sticky: remove attempted while empty

Behaviour:
- Reset (reset low, asynchronous):
  - wr/rd pointers = 0, count = 0, empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0 (unless AF_LEVEL is 0; illegal).
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
  - Memory array not cleared.
- Pointers: $clog2(DEPTH)+1 bits each (address plus wrap bit); increment modulo 2*DEPTH. count = wr_ptr - rd_ptr in the same width.
- Accept rules, evaluated on current (pre-edge) state:
  - rd_ok = remove && !empty.
  - wr_ok = insert && (!full || rd_ok).
  - Full + insert + remove: both accepted, count unchanged, pointers both advance.
  - Empty + insert + remove: write accepted; read rejected; underflow set.
  - Full + insert only: data dropped; overflow set.
  - Empty + remove only: no pop; underflow set.
- Flush (synchronous, highest priority after reset):
  - Same effect as reset, including clearing overflow/underflow.
  - insert/remove in the flush cycle are ignored and raise no error.
- Flags full, empty, almost_full, almost_empty and count are registered and reflect the post-update occupancy at the same edge that commits the operation; no combinational path from insert/remove to flags.
- Default read mode: one-cycle latency.
  - On an edge with rd_ok, data_out <= mem[rd_addr] and data_valid <= 1.
  - Otherwise data_valid <= 0 and data_out holds its last value.
- Write: on wr_ok, mem[wr_addr] <= data_in. Write-then-read of the same entry needs at least one cycle between them (guaranteed by empty rule).
- Wrap-around: full when addresses equal and wrap bits differ; empty when pointers are fully equal. Verified across at least 3 laps.
- overflow/underflow stay high until reset or flush.

Optional Feature:
Macro FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out = mem[rd_addr] combinationally from the registered read pointer.
  - data_valid = !empty.
  - remove acknowledges the displayed word; the next word appears after the edge.
  - Zero read latency.
  - Accept rules, flags and errors are unchanged.
- Undefined: registered one-cycle read behaviour as specified above.

Test Plan:
Defaults used throughout: WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
- Reset then idle 3 cycles -> empty=1, almost_empty=1, full=0, count=0, data_out=0x00, data_valid=0, overflow=underflow=0.
- Insert 0x01..0x08 on consecutive cycles -> count steps 1..8; almost_empty drops after count=2; almost_full rises at count=6; full at count=8. 9th insert 0xFF -> overflow=1, count stays 8. Then 8 removes -> data_out 0x01..0x08 each one cycle after its remove with data_valid=1; 0xFF never appears.
- Empty FIFO, remove=1 one cycle -> underflow=1, data_valid=0, count=0. Same cycle insert 0xA5 -> count=1, underflow=1.
- Full FIFO, insert 0x55 and remove together for 4 cycles -> count stays 8, full stays 1, no overflow; oldest 4 words popped in order.
- Fill to 5, assert flush with insert=1, remove=1 -> next cycle count=0, empty=1, errors 0. Assert reset mid-fill -> flags return to reset values immediately, without waiting for a clock edge.
- 30 inserts / 30 removes interleaved, pattern i*3 mod 256 -> output order exact across 3+ pointer wraps. With FIFO_FWFT_EN defined, same data appears on data_out with data_valid=!empty before each remove.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise reads have one cycle of latency.

module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     insert,
    input  logic                     remove,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT   = PW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg, almost_full_reg, almost_empty_reg;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          rd_ok, wr_ok, wr_en;
    logic [AW-1:0] wr_addr, rd_addr;

    assign wr_addr = wr_ptr_reg[AW-1:0];
    assign rd_addr = rd_ptr_reg[AW-1:0];

    // Accept decisions use only registered state, so a pop frees room for a same-cycle push.
    always_comb begin
        rd_ok          = remove && !empty_reg;
        wr_ok          = insert && (!full_reg || rd_ok);
        wr_en          = wr_ok && !flush;
        wr_ptr_next    = wr_ptr_reg + {{AW{1'b0}}, wr_ok};
        rd_ptr_next    = rd_ptr_reg + {{AW{1'b0}}, rd_ok};
        count_next     = wr_ptr_next - rd_ptr_next;
        overflow_next  = overflow_reg | (insert && !wr_ok);
        underflow_next = underflow_reg | (remove && empty_reg);
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            full_reg         <= (count_next == FULL_CNT);
            empty_reg        <= (count_next == '0);
            almost_full_reg  <= (count_next >= AF_CNT);
            almost_empty_reg <= (count_next <= AE_CNT);
            overflow_reg     <= overflow_next;
            underflow_reg    <= underflow_next;
        end
    end

    // Storage is deliberately left uninitialised; occupancy tracking guards every read.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown straight from the array; remove only advances the read pointer.
    assign data_out   = mem[rd_addr];
    assign data_valid = !empty_reg;
`else
    logic [WIDTH-1:0] data_out_reg;
    logic             data_valid_reg;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
        end else if (flush) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            data_valid_reg <= rd_ok;
            if (rd_ok) begin
                data_out_reg <= mem[rd_addr];
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
`endif

    assign count        = count_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule
